// File: rtl/XT_BUS.sv
// XT local-bus slave request type and address match helpers shared by the
// peripherals that sit on the bus.
package XT_BUS;

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } lb_slave_t;

    function automatic logic MatchWLB(input lb_slave_t lb, input logic [7:0] addr);
        return lb.wr && (lb.addr == addr);
    endfunction

    function automatic logic MatchRLB(input lb_slave_t lb, input logic [7:0] addr);
        return lb.rd && (lb.addr == addr);
    endfunction

endpackage

// File: rtl/led_seq_lbus_pkg.sv
// Register addresses, bit positions and sequencer state type for led_seq_lbus.
package led_seq_lbus_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'd21;
    localparam logic [7:0] ADDR_PERIOD = 8'd22;
    localparam logic [7:0] ADDR_PAT    = 8'd23;
    localparam logic [7:0] ADDR_STATUS = 8'd24;
    localparam logic [7:0] ADDR_BRIGHT = 8'd25;

    localparam int CTRL_RUN   = 0;
    localparam int CTRL_LOOP  = 1;
    localparam int CTRL_CLEAR = 2;
    localparam int CTRL_BUSY  = 3;
    localparam int STATUS_OVF = 8;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_e;

endpackage

// File: rtl/led_pwm_gate.sv
// Free-running 8-bit PWM counter; on is high while the count is below duty.
// Only built when LED_SEQ_PWM_EN is defined.
`ifdef LED_SEQ_PWM_EN
module led_pwm_gate (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] duty,
    output logic       on
);

    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign on = (cnt_q < duty);

endmodule
`endif

// File: rtl/led_seq_lbus.sv
// Local-bus LED pattern sequencer: buffers CPU-written patterns and steps
// through them at a programmable rate. LED_SEQ_PWM_EN adds brightness PWM.
module led_seq_lbus
    import XT_BUS::*;
    import led_seq_lbus_pkg::*;
#(
    parameter int LED_NUM = 8,
    parameter int DEPTH   = 8
) (
    input  logic               lb_clk,
    input  logic               rst_n,
    input  lb_slave_t          xt_lb,
    output logic [31:0]        rdata,
    output logic [LED_NUM-1:0] led
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0]   IDX_ONE   = 1;
    localparam logic [4:0]         COUNT_MAX = 5'(DEPTH);
    localparam logic [LED_NUM-1:0] LED_OFF   = '1;

    seq_state_e         state_q;
    logic               loop_q;
    logic [23:0]        period_q;
    logic [4:0]         count_q;
    logic [IDX_W-1:0]   idx_q;
    logic [24:0]        step_q;
    logic               ovf_q;
    logic [LED_NUM-1:0] led_q;
    logic [LED_NUM-1:0] pat_mem [DEPTH];

    logic wr_ctrl, wr_period, wr_pat, wr_status;
    logic busy, last_step, pwm_on;
    logic unused_bits;

    assign wr_ctrl   = MatchWLB(xt_lb, ADDR_CTRL);
    assign wr_period = MatchWLB(xt_lb, ADDR_PERIOD);
    assign wr_pat    = MatchWLB(xt_lb, ADDR_PAT);
    assign wr_status = MatchWLB(xt_lb, ADDR_STATUS);

    assign busy        = (state_q == SEQ_RUN);
    assign last_step   = (5'(idx_q) == (count_q - 5'd1));
    assign led         = led_q;
    assign unused_bits = ^xt_lb.wdata[31:24];

`ifdef LED_SEQ_PWM_EN
    logic [7:0] bright_q;
    logic       wr_bright;

    assign wr_bright = MatchWLB(xt_lb, ADDR_BRIGHT);

    always_ff @(posedge lb_clk or negedge rst_n) begin
        if (!rst_n) begin
            bright_q <= 8'hFF;
        end else if (wr_bright) begin
            bright_q <= xt_lb.wdata[7:0];
        end
    end

    led_pwm_gate u_pwm (
        .clk   (lb_clk),
        .rst_n (rst_n),
        .duty  (bright_q),
        .on    (pwm_on)
    );
`else
    assign pwm_on = 1'b1;
`endif

    // Buffer has no reset; contents are only meaningful below count_q.
    always_ff @(posedge lb_clk) begin
        if (wr_pat && (count_q != COUNT_MAX)) begin
            pat_mem[count_q[IDX_W-1:0]] <= xt_lb.wdata[LED_NUM-1:0];
        end
    end

    // led is updated on the same edge as state/idx so BUSY and the LED drive
    // change together; the entry cycle shows all-off and loads PERIOD+1 so the
    // first pattern still gets its full PERIOD+1 cycles.
    always_ff @(posedge lb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SEQ_IDLE;
            loop_q   <= 1'b0;
            period_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            step_q   <= '0;
            ovf_q    <= 1'b0;
            led_q    <= LED_OFF;
        end else begin
            if (wr_pat) begin
                if (count_q == COUNT_MAX) begin
                    ovf_q <= 1'b1;
                end else begin
                    count_q <= count_q + 5'd1;
                end
            end
            if (wr_status && xt_lb.wdata[STATUS_OVF]) begin
                ovf_q <= 1'b0;
            end
            if (wr_period) begin
                period_q <= xt_lb.wdata[23:0];
            end
            if (wr_ctrl) begin
                loop_q <= xt_lb.wdata[CTRL_LOOP];
            end

            if (wr_ctrl && xt_lb.wdata[CTRL_CLEAR]) begin
                count_q <= '0;
                idx_q   <= '0;
                state_q <= SEQ_IDLE;
                led_q   <= LED_OFF;
            end else begin
                case (state_q)
                    SEQ_IDLE: begin
                        led_q <= LED_OFF;
                        if (wr_ctrl && xt_lb.wdata[CTRL_RUN] && (count_q != 5'd0)) begin
                            state_q <= SEQ_RUN;
                            idx_q   <= '0;
                            step_q  <= {1'b0, period_q} + 25'd1;
                        end
                    end
                    SEQ_RUN: begin
                        if (wr_ctrl && !xt_lb.wdata[CTRL_RUN]) begin
                            state_q <= SEQ_IDLE;
                            idx_q   <= '0;
                            led_q   <= LED_OFF;
                        end else if (step_q == 25'd0) begin
                            step_q <= {1'b0, period_q};
                            if (!last_step) begin
                                idx_q <= idx_q + IDX_ONE;
                                led_q <= pwm_on ? pat_mem[idx_q + IDX_ONE] : LED_OFF;
                            end else if (loop_q) begin
                                idx_q <= '0;
                                led_q <= pwm_on ? pat_mem[0] : LED_OFF;
                            end else begin
                                state_q <= SEQ_IDLE;
                                idx_q   <= '0;
                                led_q   <= LED_OFF;
                            end
                        end else begin
                            step_q <= step_q - 25'd1;
                            led_q  <= pwm_on ? pat_mem[idx_q] : LED_OFF;
                        end
                    end
                    default: state_q <= SEQ_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (MatchRLB(xt_lb, ADDR_CTRL)) begin
            rdata[CTRL_RUN]  = busy;
            rdata[CTRL_LOOP] = loop_q;
            rdata[CTRL_BUSY] = busy;
            rdata[11:8]      = 4'(idx_q);
        end else if (MatchRLB(xt_lb, ADDR_PERIOD)) begin
            rdata[23:0] = period_q;
        end else if (MatchRLB(xt_lb, ADDR_PAT)) begin
            rdata[LED_NUM-1:0] = led_q;
        end else if (MatchRLB(xt_lb, ADDR_STATUS)) begin
            rdata[4:0]        = count_q;
            rdata[STATUS_OVF] = ovf_q;
        end
`ifdef LED_SEQ_PWM_EN
        else if (MatchRLB(xt_lb, ADDR_BRIGHT)) begin
            rdata[7:0] = bright_q;
        end
`endif
    end

endmodule

// File: tb/tb_led_seq_lbus.sv
// Randomized self-checking bench for led_seq_lbus (default build, LED_NUM=8,
// DEPTH=8) against a position-arithmetic model of the pattern sequence.
module tb_led_seq_lbus;
    import XT_BUS::*;

    localparam logic [7:0] A_CTRL   = 8'd21;
    localparam logic [7:0] A_PERIOD = 8'd22;
    localparam logic [7:0] A_PAT    = 8'd23;
    localparam logic [7:0] A_STATUS = 8'd24;
    localparam logic [7:0] A_BRIGHT = 8'd25;
    localparam int         M_DEPTH  = 8;

    logic        lb_clk;
    logic        rst_n;
    lb_slave_t   xt_lb;
    logic [31:0] rdata;
    logic [7:0]  led;

    int total = 0;
    int bad   = 0;

    // model of the pattern buffer and sticky overflow flag
    logic [7:0] exp_q[$];
    bit         mdl_ovf;

    led_seq_lbus #(.LED_NUM(8), .DEPTH(8)) dut (
        .lb_clk (lb_clk),
        .rst_n  (rst_n),
        .xt_lb  (xt_lb),
        .rdata  (rdata),
        .led    (led)
    );

    initial lb_clk = 1'b0;
    always #5 lb_clk = ~lb_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge lb_clk);
        xt_lb.addr  = a;
        xt_lb.wdata = d;
        xt_lb.wr    = 1'b1;
        @(posedge lb_clk);
        #1;
        xt_lb.wr = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        xt_lb.addr = a;
        xt_lb.rd   = 1'b1;
        #1;
        d = rdata;
        xt_lb.rd = 1'b0;
    endtask

    task automatic push_pat(input logic [7:0] d);
        bus_write(A_PAT, {24'd0, d});
        if (exp_q.size() < M_DEPTH) exp_q.push_back(d);
        else mdl_ovf = 1'b1;
    endtask

    task automatic clear_buf();
        bus_write(A_CTRL, 32'h4);
        exp_q.delete();
    endtask

    function automatic logic [31:0] status_exp();
        return {23'd0, mdl_ovf, 3'd0, 5'(exp_q.size())};
    endfunction

    // After the RUN write edge N, the pattern seen after edge N+k is at
    // position (k-1)/(p+1) in the sequence; one-shot ends after n*(p+1) cycles.
    task automatic run_check(input int p, input bit loop_en);
        int          n, span, pos, idx;
        bit          busy;
        logic [7:0]  exp_led;
        logic [31:0] rd;
        n    = exp_q.size();
        span = loop_en ? 2 * n * (p + 1) + 3 : n * (p + 1) + 2;
        bus_write(A_PERIOD, p);
        bus_read(A_PERIOD, rd);
        check("period_rd", rd, p);
        bus_write(A_CTRL, {30'd0, loop_en, 1'b1});
        for (int k = 0; k <= span; k++) begin
            if (k > 0) begin
                @(posedge lb_clk);
                #1;
            end
            busy = 1'b1; idx = 0; exp_led = 8'hFF;
            if (k > 0) begin
                pos = (k - 1) / (p + 1);
                if (loop_en || pos < n) begin
                    idx     = pos % n;
                    exp_led = exp_q[idx];
                end else begin
                    busy = 1'b0;
                end
            end
            check($sformatf("led k=%0d", k), {24'd0, led}, {24'd0, exp_led});
            bus_read(A_CTRL, rd);
            check($sformatf("ctrl k=%0d", k), rd,
                  (idx << 8) | (32'(busy) << 3) | (32'(loop_en) << 1) | 32'(busy));
            if (k == 1) begin
                bus_read(A_PAT, rd);
                check("pat_rd", rd, {24'd0, exp_led});
            end
        end
        if (loop_en) begin
            bus_write(A_CTRL, 32'h0);
            check("stop_led", {24'd0, led}, 32'hFF);
            bus_read(A_CTRL, rd);
            check("stop_ctrl", rd, 32'h0);
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          n;
        xt_lb   = '0;
        rst_n   = 1'b0;
        mdl_ovf = 1'b0;
        repeat (3) @(posedge lb_clk);
        #1;
        check("rst_led", {24'd0, led}, 32'hFF);
        bus_read(A_CTRL, rd);   check("rst_ctrl", rd, 32'h0);
        bus_read(A_STATUS, rd); check("rst_status", rd, 32'h0);
        bus_read(A_PERIOD, rd); check("rst_period", rd, 32'h0);
        @(negedge lb_clk);
        rst_n = 1'b1;

`ifdef LED_SEQ_PWM_EN
        bus_read(A_BRIGHT, rd); check("bright_rst", rd, 32'hFF);
`else
        bus_write(A_BRIGHT, 32'h40);
        bus_read(A_BRIGHT, rd); check("bright_absent", rd, 32'h0);
`endif

        // RUN with an empty buffer is ignored
        bus_write(A_CTRL, 32'h1);
        bus_read(A_CTRL, rd); check("run_empty_ctrl", rd, 32'h0);
        @(posedge lb_clk); #1;
        check("run_empty_led", {24'd0, led}, 32'hFF);

        // directed one-shot then loop over 01,02,04 with PERIOD=3
        push_pat(8'h01); push_pat(8'h02); push_pat(8'h04);
        bus_read(A_STATUS, rd); check("status3", rd, status_exp());
        run_check(3, 1'b0);
        run_check(3, 1'b1);

        // overflow: nine pushes into eight entries
        clear_buf();
        for (int i = 0; i < 9; i++) push_pat(8'(i + 1));
        bus_read(A_STATUS, rd); check("ovf_set", rd, status_exp());
        bus_write(A_STATUS, 32'h100);
        mdl_ovf = 1'b0;
        bus_read(A_STATUS, rd); check("ovf_clr", rd, status_exp());

        // CLEAR in the middle of a looping run
        bus_write(A_PERIOD, 32'd1);
        bus_write(A_CTRL, 32'h3);
        repeat (5) @(posedge lb_clk);
        clear_buf();
        check("clr_led", {24'd0, led}, 32'hFF);
        bus_read(A_CTRL, rd);   check("clr_ctrl", rd, 32'h0);
        bus_read(A_STATUS, rd); check("clr_status", rd, status_exp());

        // randomized runs
        for (int t = 0; t < 6; t++) begin
            clear_buf();
            n = $urandom_range(1, M_DEPTH);
            for (int i = 0; i < n; i++) push_pat(8'($urandom_range(0, 255)));
            bus_read(A_STATUS, rd); check("rnd_status", rd, status_exp());
            run_check($urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        // asynchronous reset in the middle of a looping run
        clear_buf();
        push_pat(8'h5A); push_pat(8'hA5);
        bus_write(A_CTRL, 32'h3);
        repeat (3) @(posedge lb_clk);
        @(negedge lb_clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        mdl_ovf = 1'b0;
        #1;
        check("arst_led", {24'd0, led}, 32'hFF);
        bus_read(A_STATUS, rd); check("arst_status", rd, status_exp());
        bus_read(A_CTRL, rd);   check("arst_ctrl", rd, 32'h0);
        @(negedge lb_clk);
        rst_n = 1'b1;
        repeat (2) @(posedge lb_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
